// File: rtl/coax_fifo_pkg.sv
// Shared definitions for the coax level FIFO: default geometry, level-width helper
// and the per-cycle operation encoding.
package coax_fifo_pkg;

  localparam int DEFAULT_WIDTH = 10;
  localparam int DEFAULT_DEPTH = 256;

  // One extra bit so the level can represent DEPTH itself.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/coax_fifo_ram.sv
// Simple dual-port storage for the coax FIFO: one write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the output register resets.
module coax_fifo_ram
  import coax_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_r[write_addr] <= write_data;
    end
  end

  // Registered read port; holds its word until the next accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= {WIDTH{1'b0}};
    end else if (read_en) begin
      read_data <= mem_r[read_addr];
    end
  end

endmodule

// File: rtl/coax_level_fifo.sv
// Synchronous FIFO with exact level count, programmable watermarks and flush.
// Sticky overflow/underflow flags exist only when COAX_LEVEL_FIFO_ERROR_FLAGS_EN is defined.
module coax_level_fifo
  import coax_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int LW = level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_strobe,
  output logic [WIDTH-1:0] read_data,
  input  logic             read_strobe,
  input  logic [LW-1:0]    almost_empty_threshold,
  input  logic [LW-1:0]    almost_full_threshold,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow,
  input  logic             error_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          wr_acc_s;
  logic          rd_acc_s;
  logic [LW-1:0] level_next_s;
  fifo_op_e      op_s;

  // Accept decisions use the registered full/empty, so a read to an empty FIFO is never bypassed.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (reset || flush) begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end else begin
      wr_acc_s = write_strobe && !full;
      rd_acc_s = read_strobe && !empty;
    end
  end

  assign op_s = fifo_op_e'({rd_acc_s, wr_acc_s});

  always_comb begin
    level_next_s = level;
    if (flush) begin
      level_next_s = {LW{1'b0}};
    end else begin
      case (op_s)
        OP_WRITE: level_next_s = level + LW'(1);
        OP_READ:  level_next_s = level - LW'(1);
        OP_NONE:  level_next_s = level;
        OP_BOTH:  level_next_s = level;
        default:  level_next_s = level;
      endcase
    end
  end

  // Pointers, level and status flags all move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      level        <= {LW{1'b0}};
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (wr_acc_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (rd_acc_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level        <= level_next_s;
      empty        <= (level_next_s == {LW{1'b0}});
      full         <= (level_next_s == LEVEL_MAX);
      almost_empty <= (level_next_s <= almost_empty_threshold);
      almost_full  <= (level_next_s >= almost_full_threshold);
    end
  end

  coax_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk        (clk),
    .reset      (reset),
    .write_en   (wr_acc_s),
    .write_addr (wr_ptr_r),
    .write_data (write_data),
    .read_en    (rd_acc_s),
    .read_addr  (rd_ptr_r),
    .read_data  (read_data)
  );

`ifdef COAX_LEVEL_FIFO_ERROR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;
  logic wr_rej_s;
  logic rd_rej_s;

  assign wr_rej_s = write_strobe && full && !flush;
  assign rd_rej_s = read_strobe && empty && !flush;

  // Sticky error flags; a new rejection wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_rej_s)         overflow_r <= 1'b1;
      else if (error_clear) overflow_r <= 1'b0;
      if (rd_rej_s)         underflow_r <= 1'b1;
      else if (error_clear) underflow_r <= 1'b0;
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`else
  logic unused_error_clear_s;
  assign unused_error_clear_s = error_clear;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_coax_level_fifo.sv
// Bench for coax_level_fifo: directed scenarios on a DEPTH=256 instance and a random
// strobe run on a DEPTH=4 instance, both against a queue-based reference model.
module tb_coax_level_fifo;

`ifdef COAX_LEVEL_FIFO_ERROR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=256 instance signals
  logic       a_reset, a_flush, a_ws, a_rs, a_ec;
  logic [9:0] a_wd, a_rd;
  logic [8:0] a_aeth, a_afth, a_level;
  logic       a_empty, a_full, a_ae, a_af, a_ov, a_un;

  // DEPTH=4 instance signals
  logic       b_reset, b_flush, b_ws, b_rs, b_ec;
  logic [9:0] b_wd, b_rd;
  logic [2:0] b_aeth, b_afth, b_level;
  logic       b_empty, b_full, b_ae, b_af, b_ov, b_un;

  coax_level_fifo #(.WIDTH(10), .DEPTH(256)) dut_a (
    .clk(clk), .reset(a_reset), .flush(a_flush), .write_data(a_wd), .write_strobe(a_ws),
    .read_data(a_rd), .read_strobe(a_rs), .almost_empty_threshold(a_aeth),
    .almost_full_threshold(a_afth), .level(a_level), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .overflow(a_ov), .underflow(a_un),
    .error_clear(a_ec)
  );

  coax_level_fifo #(.WIDTH(10), .DEPTH(4)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush), .write_data(b_wd), .write_strobe(b_ws),
    .read_data(b_rd), .read_strobe(b_rs), .almost_empty_threshold(b_aeth),
    .almost_full_threshold(b_afth), .level(b_level), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .overflow(b_ov), .underflow(b_un),
    .error_clear(b_ec)
  );

  // Reference state: contents as a queue, plus expected registered outputs.
  int         qa[$];
  int         qb[$];
  logic [9:0] ma_rd, mb_rd;
  bit         ma_ov, ma_un, ma_ae, ma_af;
  bit         mb_ov, mb_un, mb_ae, mb_af;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the FIFO behaviour, expressed on the queue.
  task automatic model(input int depth, input bit rst, input bit fl, input bit ws,
                       input bit rs, input bit ec, input logic [9:0] wd,
                       input int aeth, input int afth, ref int q[$],
                       ref logic [9:0] rd, ref bit ov, ref bit un, ref bit ae, ref bit af);
    bit wa, ra;
    wa = 1'b0;
    ra = 1'b0;
    if (rst) begin
      q.delete();
      rd = 10'd0; ov = 1'b0; un = 1'b0; ae = 1'b1; af = 1'b0;
    end else if (fl) begin
      q.delete();
      ae = (0 <= aeth);
      af = (0 >= afth);
      ov = ov && !ec;
      un = un && !ec;
    end else begin
      wa = ws && (q.size() < depth);
      ra = rs && (q.size() > 0);
      if (ra) rd = 10'(q.pop_front());
      if (wa) q.push_back(int'(wd));
      ov = ERR_EN && ((ws && !wa) || (ov && !ec));
      un = ERR_EN && ((rs && !ra) || (un && !ec));
      ae = (q.size() <= aeth);
      af = (q.size() >= afth);
    end
  endtask

  task automatic check_a(input string ph);
    chk({ph, ":level"}, 32'(a_level), 32'(qa.size()));
    chk({ph, ":empty"}, 32'(a_empty), 32'(qa.size() == 0));
    chk({ph, ":full"},  32'(a_full),  32'(qa.size() == 256));
    chk({ph, ":almost_empty"}, 32'(a_ae), 32'(ma_ae));
    chk({ph, ":almost_full"},  32'(a_af), 32'(ma_af));
    chk({ph, ":overflow"},  32'(a_ov), 32'(ma_ov));
    chk({ph, ":underflow"}, 32'(a_un), 32'(ma_un));
    chk({ph, ":read_data"}, 32'(a_rd), 32'(ma_rd));
  endtask

  task automatic check_b(input string ph);
    chk({ph, ":level"}, 32'(b_level), 32'(qb.size()));
    chk({ph, ":empty"}, 32'(b_empty), 32'(qb.size() == 0));
    chk({ph, ":full"},  32'(b_full),  32'(qb.size() == 4));
    chk({ph, ":almost_empty"}, 32'(b_ae), 32'(mb_ae));
    chk({ph, ":almost_full"},  32'(b_af), 32'(mb_af));
    chk({ph, ":overflow"},  32'(b_ov), 32'(mb_ov));
    chk({ph, ":underflow"}, 32'(b_un), 32'(mb_un));
    chk({ph, ":read_data"}, 32'(b_rd), 32'(mb_rd));
  endtask

  task automatic step_a(input string ph);
    @(posedge clk);
    model(256, a_reset, a_flush, a_ws, a_rs, a_ec, a_wd, int'(a_aeth), int'(a_afth),
          qa, ma_rd, ma_ov, ma_un, ma_ae, ma_af);
    #1;
    check_a(ph);
  endtask

  task automatic step_b(input string ph);
    @(posedge clk);
    model(4, b_reset, b_flush, b_ws, b_rs, b_ec, b_wd, int'(b_aeth), int'(b_afth),
          qb, mb_rd, mb_ov, mb_un, mb_ae, mb_af);
    #1;
    check_b(ph);
  endtask

  task automatic set_a(input bit ws, input bit rs, input logic [9:0] wd);
    a_ws = ws;
    a_rs = rs;
    a_wd = wd;
  endtask

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_ec = 1'b0; set_a(1'b0, 1'b0, 10'd0);
    a_aeth = 9'd4; a_afth = 9'd8;
    b_reset = 1'b1; b_flush = 1'b0; b_ec = 1'b0; b_ws = 1'b0; b_rs = 1'b0;
    b_wd = 10'd0; b_aeth = 3'd1; b_afth = 3'd3;

    // Reset values
    step_a("reset");
    a_reset = 1'b0;

    // Fill with 0x001..0x100, then drain in order
    for (int i = 1; i <= 256; i++) begin
      set_a(1'b1, 1'b0, 10'(i));
      step_a("fill");
    end
    set_a(1'b0, 1'b1, 10'd0);
    for (int i = 0; i < 256; i++) step_a("drain");

    // Full with both strobes: read wins, write rejected
    for (int i = 0; i < 256; i++) begin
      set_a(1'b1, 1'b0, 10'($urandom));
      step_a("refill");
    end
    set_a(1'b1, 1'b1, 10'h3FF);
    step_a("full_both");
    set_a(1'b0, 1'b0, 10'd0);
    a_ec = 1'b1;
    step_a("ovf_clear");
    a_ec = 1'b0;
    set_a(1'b0, 1'b1, 10'd0);
    for (int i = 0; i < 255; i++) step_a("drain2");
    step_a("read_empty");
    set_a(1'b0, 1'b0, 10'd0);
    a_ec = 1'b1;
    step_a("unf_clear");
    a_ec = 1'b0;

    // Empty with both strobes: write wins, read rejected
    set_a(1'b1, 1'b1, 10'h155);
    step_a("empty_both");
    set_a(1'b0, 1'b1, 10'd0);
    step_a("read_155");
    set_a(1'b0, 1'b0, 10'd0);
    a_ec = 1'b1;
    step_a("unf_clear2");
    a_ec = 1'b0;

    // Watermarks 4/8 over nine writes, then raise almost-full threshold while idle
    a_aeth = 9'd4; a_afth = 9'd8;
    for (int i = 0; i < 9; i++) begin
      set_a(1'b1, 1'b0, 10'($urandom));
      step_a("watermark");
    end
    set_a(1'b0, 1'b0, 10'd0);
    a_afth = 9'd10;
    step_a("thr_change");

    // Flush at level 37 with both strobes, after a known word has been read
    for (int i = 0; i < 29; i++) begin
      set_a(1'b1, 1'b0, 10'($urandom));
      step_a("to_38");
    end
    set_a(1'b0, 1'b1, 10'd0);
    step_a("to_37");
    set_a(1'b1, 1'b1, 10'($urandom));
    a_flush = 1'b1;
    step_a("flush");
    a_flush = 1'b0;

    // Reset at level 37 with both strobes
    for (int i = 0; i < 37; i++) begin
      set_a(1'b1, 1'b0, 10'($urandom));
      step_a("refill37");
    end
    set_a(1'b1, 1'b1, 10'($urandom));
    a_reset = 1'b1;
    step_a("reset_mid");
    a_reset = 1'b0;
    set_a(1'b0, 1'b0, 10'd0);

    // DEPTH=4: random strobes, thresholds, occasional flush and error clear
    step_b("b_reset");
    b_reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      b_ws    = 1'($urandom_range(0, 1));
      b_rs    = 1'($urandom_range(0, 1));
      b_wd    = 10'($urandom);
      b_flush = ($urandom_range(0, 63) == 0);
      b_ec    = ($urandom_range(0, 7) == 0);
      b_aeth  = 3'($urandom_range(0, 4));
      b_afth  = 3'($urandom_range(0, 4));
      step_b("wrap");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
